// File: rtl/pooling_stream_layer_if.sv
// Pixel-in / pooled-value-out stream bundle for pooling_stream_layer.
// master drives pixels and out_ready; slave is the pooling layer.
interface pooling_stream_layer_if #(
  parameter int DATA_W = 8,
  parameter int OUT_W  = 16
);
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] in_data;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [OUT_W-1:0]  out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/pooling_stream_layer.sv
// Streaming POOLxPOOL average (or max, with POOL_MAX_EN defined) pooling over a
// raster pixel stream, using a one-row line buffer of per-window accumulators.
module pooling_stream_layer #(
  parameter int DATA_W = 8,
  parameter int OUT_W  = 16,
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28,
  parameter int POOL   = 2
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_enable,
  input  logic                   i_mode,
  pooling_stream_layer_if.slave  s_if,
  output logic                   o_frame_done
);

  localparam int LOG2  = (POOL == 4) ? 2 : 1;
  localparam int SHIFT = 2 * LOG2;
  localparam int ACC_W = DATA_W + SHIFT;
  localparam int NWIN  = IMG_W / POOL;
  localparam int CW    = $clog2(IMG_W);
  localparam int RW    = $clog2(IMG_H);
  localparam int IW    = CW - LOG2;

  if (POOL != 2 && POOL != 4) begin : g_bad_pool
    $error("pooling_stream_layer: POOL must be 2 or 4");
  end
  if ((IMG_W % POOL) != 0 || (IMG_H % POOL) != 0) begin : g_bad_img
    $error("pooling_stream_layer: IMG_W and IMG_H must be multiples of POOL");
  end
  if (OUT_W < DATA_W) begin : g_bad_out
    $error("pooling_stream_layer: OUT_W must be >= DATA_W");
  end

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic [CW-1:0]            r_col;
  logic [RW-1:0]            r_row;
  logic signed [ACC_W-1:0]  r_lbuf [NWIN];
  logic                     r_out_valid;
  logic signed [OUT_W-1:0]  r_out_data;

  logic                     w_in_ready;
  logic                     w_accept;
  logic                     w_take;
  logic                     w_col_end;
  logic                     w_row_end;
  logic                     w_frame_end;
  logic                     w_first;
  logic                     w_last;
  logic [IW-1:0]            w_idx;
  logic signed [ACC_W-1:0]  w_entry;
  logic signed [ACC_W-1:0]  w_px;
  logic signed [ACC_W-1:0]  w_upd;
  logic signed [ACC_W-1:0]  w_res;

  assign w_accept    = s_if.in_valid && w_in_ready;
  assign w_take      = r_out_valid && s_if.out_ready;
  assign w_col_end   = (r_col == CW'(IMG_W - 1));
  assign w_row_end   = (r_row == RW'(IMG_H - 1));
  assign w_frame_end = w_col_end && w_row_end;
  assign w_first     = (r_col[LOG2-1:0] == '0) && (r_row[LOG2-1:0] == '0);
  assign w_last      = (&r_col[LOG2-1:0]) && (&r_row[LOG2-1:0]);
  assign w_idx       = r_col[CW-1:LOG2];
  assign w_entry     = r_lbuf[w_idx];
  assign w_px        = ACC_W'(s_if.in_data);

`ifdef POOL_MAX_EN
  logic r_mode;
  logic w_max;

  // The first pixel of a frame uses the live mode; the rest use the latched copy.
  assign w_max = (r_state == IDLE) ? i_mode : r_mode;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_mode <= 1'b0;
    end else if (w_accept && r_state == IDLE) begin
      r_mode <= i_mode;
    end
  end

  always_comb begin
    w_upd = w_px;
    if (!w_first) begin
      if (w_max) begin
        w_upd = (w_px > w_entry) ? w_px : w_entry;
      end else begin
        w_upd = w_entry + w_px;
      end
    end
  end

  assign w_res = w_max ? w_upd : (w_upd >>> SHIFT);
`else
  logic w_unused_mode;
  assign w_unused_mode = i_mode;

  always_comb begin
    w_upd = w_px;
    if (!w_first) begin
      w_upd = w_entry + w_px;
    end
  end

  assign w_res = w_upd >>> SHIFT;
`endif

  always_ff @(posedge i_clk) begin
    if (w_accept) begin
      r_lbuf[w_idx] <= w_upd;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_accept) begin
      if (w_col_end) begin
        r_col <= '0;
        r_row <= w_row_end ? '0 : r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  // A load and a take can coincide; the load wins and keeps out_valid high.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else if (w_accept && w_last) begin
      r_out_valid <= 1'b1;
      r_out_data  <= OUT_W'(w_res);
    end else if (w_take) begin
      r_out_valid <= 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (w_accept) w_state_nxt = w_frame_end ? FLUSH : RUN;
      RUN:     if (w_accept && w_frame_end) w_state_nxt = FLUSH;
      FLUSH:   if (w_take) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_in_ready   = i_enable && !i_reset && !(r_out_valid && !s_if.out_ready)
                   && (r_state != FLUSH);
    o_frame_done = !i_reset && (r_state == FLUSH) && w_take;
  end

  assign s_if.in_ready  = w_in_ready;
  assign s_if.out_valid = r_out_valid;
  assign s_if.out_data  = r_out_data;

endmodule
